// File: rtl/mac_key_extract.sv
// Ingress header parser emitting DA then SA 60-bit {VID,MAC} hash keys.
// Define MAC_KEY_VLAN_EN to enable 802.1Q TPID/TCI parsing.
module mac_key_extract #(
  parameter logic [11:0] P_DEFAULT_VID = 12'd1,
  parameter int          P_PORT_W      = 4,
  parameter logic [15:0] P_TPID        = 16'h8100
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_data,
  input  logic                i_valid,
  input  logic                i_sof,
  input  logic                i_eof,
  input  logic [P_PORT_W-1:0] i_src_port,
  output logic [59:0]         o_key,
  output logic                o_key_type,
  output logic [P_PORT_W-1:0] o_key_port,
  output logic                o_key_valid,
  input  logic                i_key_ready,
  output logic                o_hash_en,
  output logic [15:0]         o_runt_cnt,
  output logic [15:0]         o_drop_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DMAC = 3'd1;
  localparam logic [2:0] S_SMAC = 3'd2;
  localparam logic [2:0] S_SKIP = 3'd3;
`ifdef MAC_KEY_VLAN_EN
  localparam logic [2:0] S_TPID = 3'd4;
  localparam logic [2:0] S_TCI  = 3'd5;
`endif

  localparam logic [1:0] O_IDLE = 2'd0;
  localparam logic [1:0] O_DA   = 2'd1;
  localparam logic [1:0] O_SA   = 2'd2;

  logic [2:0]          pstate;
  logic [3:0]          idx;
  logic [47:0]         da;
  logic [47:0]         sa;
  logic [P_PORT_W-1:0] port_q;

  logic [1:0]          ostate;
  logic [59:0]         key_q;
  logic                type_q;
  logic [P_PORT_W-1:0] kport_q;
  logic [59:0]         sa_buf;
  logic [15:0]         runt_q;
  logic [15:0]         drop_q;

  logic        start;
  logic        active;
  logic        done;
  logic        runt;
  logic        fire;
  logic        accept;
  logic        drop;
  logic [11:0] pair_vid;
  logic [47:0] pair_sa;

  assign start  = i_valid & i_sof;
  assign active = i_valid & ~i_sof &
                  (pstate != S_IDLE) &
                  (pstate != S_SKIP);

`ifdef MAC_KEY_VLAN_EN
  logic [7:0]  tpid_hi;
  logic [3:0]  vid_hi;
  logic        tag_hit;
  logic [11:0] tci_vid;

  assign tag_hit = {tpid_hi, i_data} == P_TPID;
  assign tci_vid = {vid_hi, i_data};
  assign done    = active &
                   (((pstate == S_TPID) &
                     (idx == 4'd13) & ~tag_hit) |
                    ((pstate == S_TCI) &
                     (idx == 4'd15)));
  assign pair_vid = ((pstate == S_TCI) &&
                     (tci_vid != 12'd0)) ?
                    tci_vid : P_DEFAULT_VID;
  assign pair_sa  = sa;
`else
  logic unused_tpid;

  assign unused_tpid = ^P_TPID;
  // Last SA byte completes the pair, so fold it in directly
  assign done     = active & (pstate == S_SMAC) &
                    (idx == 4'd11);
  assign pair_vid = P_DEFAULT_VID;
  assign pair_sa  = {sa[39:0], i_data};
`endif

  assign runt = i_valid & i_eof & ~done &
                (start | active);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pstate <= S_IDLE;
      idx    <= 4'd0;
      da     <= 48'd0;
      sa     <= 48'd0;
      port_q <= '0;
`ifdef MAC_KEY_VLAN_EN
      tpid_hi <= 8'd0;
      vid_hi  <= 4'd0;
`endif
    end else if (start) begin
      pstate <= i_eof ? S_IDLE : S_DMAC;
      idx    <= 4'd1;
      da     <= {da[39:0], i_data};
      port_q <= i_src_port;
    end else if (active) begin
      idx <= idx + 4'd1;
      unique case (pstate)
        S_DMAC: begin
          da <= {da[39:0], i_data};
          if (idx == 4'd5) pstate <= S_SMAC;
        end
        S_SMAC: begin
          sa <= {sa[39:0], i_data};
`ifdef MAC_KEY_VLAN_EN
          if (idx == 4'd11) pstate <= S_TPID;
`else
          if (idx == 4'd11) pstate <= S_SKIP;
`endif
        end
`ifdef MAC_KEY_VLAN_EN
        S_TPID: begin
          if (idx == 4'd12) tpid_hi <= i_data;
          else pstate <= tag_hit ? S_TCI : S_SKIP;
        end
        S_TCI: begin
          if (idx == 4'd14) vid_hi <= i_data[3:0];
          else pstate <= S_SKIP;
        end
`endif
        default: ;
      endcase
      if (i_eof) pstate <= S_IDLE;
    end else if ((pstate == S_SKIP) &
                 i_valid & i_eof) begin
      pstate <= S_IDLE;
    end
  end

  assign o_key_valid = ostate != O_IDLE;
  assign fire        = o_key_valid & i_key_ready;
  assign o_hash_en   = fire;
  // Buffer is free if idle or its SA key leaves this cycle
  assign accept = done &
                  ((ostate == O_IDLE) |
                   ((ostate == O_SA) & fire));
  assign drop   = done & ~accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ostate  <= O_IDLE;
      key_q   <= 60'd0;
      type_q  <= 1'b0;
      kport_q <= '0;
      sa_buf  <= 60'd0;
    end else if (accept) begin
      ostate  <= O_DA;
      key_q   <= {pair_vid, da};
      type_q  <= 1'b0;
      kport_q <= port_q;
      sa_buf  <= {pair_vid, pair_sa};
    end else begin
      unique case (ostate)
        O_DA: begin
          if (fire) begin
            ostate <= O_SA;
            key_q  <= sa_buf;
            type_q <= 1'b1;
          end
        end
        O_SA: begin
          if (fire) ostate <= O_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      runt_q <= 16'd0;
      drop_q <= 16'd0;
    end else begin
      if (runt && runt_q != 16'hFFFF)
        runt_q <= runt_q + 16'd1;
      if (drop && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  assign o_key      = key_q;
  assign o_key_type = type_q;
  assign o_key_port = kport_q;
  assign o_runt_cnt = runt_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_mac_key_extract.sv
// Directed bench for mac_key_extract.
// Expectations follow MAC_KEY_VLAN_EN when defined.
module tb_mac_key_extract;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_data = 8'd0;
  logic        i_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic        i_eof = 1'b0;
  logic [3:0]  i_src_port = 4'd0;
  logic [59:0] o_key;
  logic        o_key_type;
  logic [3:0]  o_key_port;
  logic        o_key_valid;
  logic        i_key_ready = 1'b0;
  logic        o_hash_en;
  logic [15:0] o_runt_cnt;
  logic [15:0] o_drop_cnt;

  int total = 0;
  int bad   = 0;
  int nfire = 0;
  int f0;

`ifdef MAC_KEY_VLAN_EN
  localparam int CIU = 13;
  localparam int CIT = 15;
  localparam logic [11:0] VID_T = 12'h064;
`else
  localparam int CIU = 11;
  localparam int CIT = 11;
  localparam logic [11:0] VID_T = 12'h001;
`endif

  localparam logic [47:0] DA = 48'h001122334455;
  localparam logic [47:0] SA = 48'h66778899AABB;

  mac_key_extract dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_sof       (i_sof),
    .i_eof       (i_eof),
    .i_src_port  (i_src_port),
    .o_key       (o_key),
    .o_key_type  (o_key_type),
    .o_key_port  (o_key_port),
    .o_key_valid (o_key_valid),
    .i_key_ready (i_key_ready),
    .o_hash_en   (o_hash_en),
    .o_runt_cnt  (o_runt_cnt),
    .o_drop_cnt  (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk)
    if (o_hash_en === 1'b1) nfire++;

  function automatic logic [7:0] fb(
    input int i, input bit tag,
    input logic [15:0] tci);
    logic [95:0] macs;
    macs = {DA, SA};
    if (i < 12) return macs[95-8*i -: 8];
    if (i == 12) return tag ? 8'h81 : 8'h08;
    if (i == 13) return 8'h00;
    if (i == 14) return tag ? tci[15:8] : 8'h45;
    if (i == 15) return tag ? tci[7:0] : 8'h00;
    return 8'(i);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int b,
                      input bit tag,
                      input logic [15:0] tci,
                      input bit eof_last);
    for (int i = a; i <= b; i++) begin
      @(posedge i_clk);
      #2;
      i_data  = fb(i, tag, tci);
      i_valid = 1'b1;
      i_sof   = (i == 0);
      i_eof   = eof_last && (i == b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_eof   = 1'b0;
    end
  endtask

  initial begin
    #3;
    chk("rst_valid", o_key_valid, 0);
    chk("rst_key", o_key, 0);
    chk("rst_type", o_key_type, 0);
    chk("rst_port", o_key_port, 0);
    chk("rst_hash", o_hash_en, 0);
    chk("rst_runt", o_runt_cnt, 0);
    chk("rst_drop", o_drop_cnt, 0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;

    // untagged, ready high
    i_key_ready = 1'b1;
    i_src_port  = 4'd3;
    send(0, CIU, 0, 16'h0, 0);
    chk("u_not_yet", o_key_valid, 0);
    idle(1);
    chk("u_da_valid", o_key_valid, 1);
    chk("u_da_type", o_key_type, 0);
    chk("u_da_key", o_key, {12'h001, DA});
    chk("u_da_port", o_key_port, 3);
    chk("u_da_hash", o_hash_en, 1);
    idle(1);
    chk("u_sa_valid", o_key_valid, 1);
    chk("u_sa_type", o_key_type, 1);
    chk("u_sa_key", o_key, {12'h001, SA});
    chk("u_sa_hash", o_hash_en, 1);
    idle(1);
    chk("u_done", o_key_valid, 0);
    send(CIU + 1, 59, 0, 16'h0, 1);
    idle(2);
    chk("u_nfire", nfire, 2);
    chk("u_runt", o_runt_cnt, 0);

    // tagged, VID 0x064
    send(0, CIT, 1, 16'hA064, 0);
    idle(1);
    chk("t_da_key", o_key, {VID_T, DA});
    idle(1);
    chk("t_sa_key", o_key, {VID_T, SA});
    idle(1);
    send(CIT + 1, 59, 1, 16'hA064, 1);

    // tagged, VID 0 maps to default
    send(0, CIT, 1, 16'h0000, 0);
    idle(1);
    chk("t0_da_key", o_key, {12'h001, DA});
    idle(1);
    chk("t0_sa_key", o_key, {12'h001, SA});
    idle(1);
    send(CIT + 1, 59, 1, 16'h0000, 1);
    idle(1);

    // runt: eof on byte 9
    f0 = nfire;
    send(0, 9, 0, 16'h0, 1);
    idle(1);
    chk("r_valid", o_key_valid, 0);
    idle(2);
    chk("r_cnt", o_runt_cnt, 1);
    chk("r_nfire", nfire, f0);
    send(0, CIU, 0, 16'h0, 0);
    idle(1);
    chk("r_next_da", o_key, {12'h001, DA});
    chk("r_next_v", o_key_valid, 1);
    idle(2);
    send(CIU + 1, 59, 0, 16'h0, 1);
    idle(1);

    // backpressure and drop
    f0 = nfire;
    i_key_ready = 1'b0;
    i_src_port  = 4'd3;
    send(0, CIU, 0, 16'h0, 0);
    idle(1);
    chk("b_valid", o_key_valid, 1);
    chk("b_hash", o_hash_en, 0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("b_stable_key", o_key, {12'h001, DA});
      chk("b_stable_hash", o_hash_en, 0);
    end
    send(CIU + 1, 59, 0, 16'h0, 1);
    i_src_port = 4'd5;
    send(0, CIU, 0, 16'h0, 0);
    idle(1);
    chk("b_drop", o_drop_cnt, 1);
    chk("b_held_port", o_key_port, 3);
    chk("b_held_type", o_key_type, 0);
    chk("b_nfire0", nfire, f0);
    i_key_ready = 1'b1;
    #1;
    chk("b_fire", o_hash_en, 1);
    idle(1);
    chk("b_sa_type", o_key_type, 1);
    chk("b_sa_port", o_key_port, 3);
    chk("b_sa_key", o_key, {12'h001, SA});
    idle(1);
    chk("b_empty", o_key_valid, 0);
    send(CIU + 1, 59, 0, 16'h0, 1);
    idle(2);
    chk("b_nfire", nfire, f0 + 2);

    // sof at byte 7 restarts
    i_src_port = 4'd6;
    send(0, 6, 0, 16'h0, 0);
    i_src_port = 4'd7;
    send(0, CIU, 0, 16'h0, 0);
    idle(1);
    chk("s_da_key", o_key, {12'h001, DA});
    chk("s_port", o_key_port, 7);
    idle(2);
    send(CIU + 1, 59, 0, 16'h0, 1);
    idle(1);
    chk("s_runt", o_runt_cnt, 1);

    // async reset with DA pending
    i_key_ready = 1'b0;
    i_src_port  = 4'd2;
    send(0, CIU, 0, 16'h0, 0);
    idle(1);
    chk("a_pend", o_key_valid, 1);
    #1;
    i_rst = 1'b1;
    #1;
    chk("a_valid", o_key_valid, 0);
    chk("a_key", o_key, 0);
    chk("a_runt", o_runt_cnt, 0);
    chk("a_drop", o_drop_cnt, 0);
    i_key_ready = 1'b1;
    #1;
    chk("a_hash", o_hash_en, 0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    send(0, CIU, 0, 16'h0, 0);
    idle(1);
    chk("a_after_da", o_key, {12'h001, DA});
    chk("a_after_port", o_key_port, 2);
    idle(1);
    chk("a_after_sa", o_key, {12'h001, SA});
    idle(1);
    send(CIU + 1, 59, 0, 16'h0, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
